// File: rtl/basilisk_writeback_if.sv
// basilisk_writeback_if
//   Bundles the writeback stage's buses.
//   - Upstream result streams: in_valid, in_ready, in_result.
//   - Register-file write port: wb_valid, wb_ready, wb_reg_addr, wb_lane_mask, wb_data.
//   - Scoreboard release and retire counter: done_valid, done_reg_addr, retire_count.
//   The slave modport is the writeback block's view.
//   The master modport is the view of the surrounding FPU (or a testbench).
//   in_result packs one result per unit as {reg_addr[4:0], offset[OFFSET_W-1:0], value[31:0]}.
interface basilisk_writeback_if #(
    parameter int NUM_UNITS    = 6,
    parameter int VECTOR_WIDTH = 4,
    parameter int OFFSET_W     = 3
);
    localparam int RES_W = 5 + OFFSET_W + 32;

    logic [NUM_UNITS-1:0]            in_valid;
    logic [NUM_UNITS-1:0]            in_ready;
    logic [NUM_UNITS-1:0][RES_W-1:0] in_result;

    logic                            wb_valid;
    logic                            wb_ready;
    logic [4:0]                      wb_reg_addr;
    logic [VECTOR_WIDTH-1:0]         wb_lane_mask;
    logic [32*VECTOR_WIDTH-1:0]      wb_data;

    logic                            done_valid;
    logic [4:0]                      done_reg_addr;
    logic [31:0]                     retire_count;

    modport master (
        output in_valid, in_result, wb_ready,
        input  in_ready, wb_valid, wb_reg_addr, wb_lane_mask, wb_data,
               done_valid, done_reg_addr, retire_count
    );

    modport slave (
        input  in_valid, in_result, wb_ready,
        output in_ready, wb_valid, wb_reg_addr, wb_lane_mask, wb_data,
               done_valid, done_reg_addr, retire_count
    );
endinterface

// File: rtl/basilisk_writeback.sv
// basilisk_writeback
//   Final FPU stage. It merges the functional-unit result streams into the single float
//   register-file write port.
//   - A round-robin arbiter picks at most one unit per cycle.
//   - Accepted results pass through a 2-entry FIFO.
//   - The FIFO head drives the write port: the value is replicated into every lane, and a
//     one-hot lane mask selects the destination lane.
//   - Each completed write produces a registered scoreboard-release pulse in the following
//     cycle and increments a 32-bit retire counter.
// Ports
//   clk : clock
//   rst : synchronous active-high reset
//   bus : basilisk_writeback_if.slave
//         in_valid/in_ready/in_result  upstream results
//         wb_*                         register-file write port
//         done_*                       scoreboard release
//         retire_count                 total completed writes
module basilisk_writeback #(
    parameter int NUM_UNITS    = 6,
    parameter int VECTOR_WIDTH = 4,
    parameter int OFFSET_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    basilisk_writeback_if.slave   bus
);
    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef struct packed {
        logic [4:0]          reg_addr;
        logic [OFFSET_W-1:0] offset;
        logic [31:0]         value;
    } entry_t;

    logic [PTR_W-1:0]     rr_ptr;
    logic [1:0]           count_q;
    entry_t               fifo_mem [2];
    logic                 wr_idx;
    logic                 rd_idx;
    logic [NUM_UNITS-1:0] grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;
    int                   arb_idx;
    logic                 enq;
    logic                 deq;
    entry_t               enq_entry;
    entry_t               head;
    logic                 wb_valid_int;
    logic [31:0]          retire_cnt;
    logic                 done_q;
    logic [4:0]           done_reg_q;

    // Scan from rr_ptr upward, wrapping; the first valid unit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        arb_idx   = 0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= NUM_UNITS) arb_idx = arb_idx - NUM_UNITS;
            if (!grant_any && bus.in_valid[arb_idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(arb_idx);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    // count_q is registered, so wb_ready never reaches in_ready combinationally.
    assign bus.in_ready = (!rst && count_q != 2'd2) ? grant : '0;
    assign enq          = |bus.in_ready;
    assign enq_entry    = entry_t'(bus.in_result[grant_idx]);

    assign head         = fifo_mem[rd_idx];
    assign wb_valid_int = (count_q != 2'd0);
    assign deq          = wb_valid_int && bus.wb_ready;

    // Outputs read zero while the buffer is empty, so stale entries never show.
    assign bus.wb_valid    = wb_valid_int;
    assign bus.wb_reg_addr = wb_valid_int ? head.reg_addr : 5'd0;
    assign bus.wb_data     = wb_valid_int ? {VECTOR_WIDTH{head.value}} : '0;

    // An out-of-range offset matches no lane, giving an all-zero mask.
    always_comb begin
        bus.wb_lane_mask = '0;
        for (int k = 0; k < VECTOR_WIDTH; k++) begin
            bus.wb_lane_mask[k] = wb_valid_int && (32'(head.offset) == 32'(k));
        end
    end

    assign bus.done_valid    = done_q;
    assign bus.done_reg_addr = done_reg_q;
    assign bus.retire_count  = retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            count_q     <= 2'd0;
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            retire_cnt  <= 32'd0;
            done_q      <= 1'b0;
            done_reg_q  <= 5'd0;
        end else begin
            if (enq) begin
                fifo_mem[wr_idx] <= enq_entry;
                wr_idx           <= ~wr_idx;
                rr_ptr           <= (int'(grant_idx) == NUM_UNITS - 1) ? '0
                                                                       : grant_idx + PTR_W'(1);
            end
            if (deq) begin
                rd_idx     <= ~rd_idx;
                retire_cnt <= retire_cnt + 32'd1;
                done_reg_q <= head.reg_addr;
            end
            done_q <= deq;
            case ({enq, deq})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_basilisk_writeback.sv
module tb_basilisk_writeback;
    localparam int N  = 6;
    localparam int VW = 4;
    localparam int OW = 3;

    typedef struct packed {
        logic [4:0]    r;
        logic [OW-1:0] off;
        logic [31:0]   v;
    } res_t;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_grant;
    } arb_vec_t;

    typedef struct {
        logic [OW-1:0] off;
        logic [VW-1:0] exp_mask;
    } lane_vec_t;

    logic clk = 1'b0;
    logic rst;

    basilisk_writeback_if #(.NUM_UNITS(N), .VECTOR_WIDTH(VW), .OFFSET_W(OW)) bus ();

    basilisk_writeback #(.NUM_UNITS(N), .VECTOR_WIDTH(VW), .OFFSET_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    res_t res [N];

    // scoreboard model
    res_t        q[$];
    int          m_count = 0;
    int          m_ptr   = 0;
    logic [31:0] m_retire = 0;
    logic        m_done = 0;
    logic [4:0]  m_done_reg = 0;
    logic [N-1:0] m_last_acc;

    // values observed in the most recent step
    logic [N-1:0]  last_ready;
    logic          last_wb_valid;
    logic [VW-1:0] last_mask;
    logic [4:0]    last_reg;
    logic [31:0]   last_retire;
    logic          last_done;
    logic [1:0]    last_count;
    logic [2:0]    last_rrptr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: compare DUT outputs against the model, then advance the model.
    task automatic step();
        logic [N-1:0] g;
        logic [N-1:0] exp_ready;
        int           gi;
        int           idx;
        bit           deq;
        res_t         h;
        logic [VW-1:0] emask;
        for (int i = 0; i < N; i++) bus.in_result[i] = res[i];
        #1;
        g  = '0;
        gi = -1;
        for (int i = 0; i < N; i++) begin
            idx = (m_ptr + i) % N;
            if (gi < 0 && bus.in_valid[idx]) gi = idx;
        end
        if (gi >= 0) g[gi] = 1'b1;
        exp_ready = (!rst && m_count < 2) ? g : '0;

        last_ready    = bus.in_ready;
        last_wb_valid = bus.wb_valid;
        last_mask     = bus.wb_lane_mask;
        last_reg      = bus.wb_reg_addr;
        last_retire   = bus.retire_count;
        last_done     = bus.done_valid;
        last_count    = dut.count_q;
        last_rrptr    = dut.rr_ptr;

        chk("in_ready", bus.in_ready, exp_ready);
        chk("wb_valid", bus.wb_valid, m_count != 0);
        chk("count", dut.count_q, m_count);
        chk("rr_ptr", dut.rr_ptr, m_ptr);
        if (m_count != 0) begin
            h     = q[0];
            emask = (h.off < VW) ? VW'(1 << h.off) : '0;
            chk("wb_reg_addr", bus.wb_reg_addr, h.r);
            chk("wb_lane_mask", bus.wb_lane_mask, emask);
            chk("wb_data", bus.wb_data, {VW{h.v}});
        end
        chk("done_valid", bus.done_valid, m_done);
        if (m_done) chk("done_reg_addr", bus.done_reg_addr, m_done_reg);
        chk("retire_count", bus.retire_count, m_retire);

        m_last_acc = exp_ready;
        if (rst) begin
            q.delete();
            m_count  = 0;
            m_ptr    = 0;
            m_retire = 0;
            m_done   = 0;
        end else begin
            deq    = (m_count != 0) && bus.wb_ready;
            m_done = deq;
            if (deq) begin
                m_done_reg = q[0].r;
                void'(q.pop_front());
                m_retire++;
            end
            if (exp_ready != 0) begin
                q.push_back(res[gi]);
                m_ptr = (gi + 1) % N;
            end
            m_count = q.size();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    arb_vec_t  arb_tbl [7];
    lane_vec_t lane_tbl [6];
    int        base;

    initial begin
        arb_tbl[0] = '{6'h3F, 6'h01};
        arb_tbl[1] = '{6'h3F, 6'h02};
        arb_tbl[2] = '{6'h3F, 6'h04};
        arb_tbl[3] = '{6'h3F, 6'h08};
        arb_tbl[4] = '{6'h3F, 6'h10};
        arb_tbl[5] = '{6'h3F, 6'h20};
        arb_tbl[6] = '{6'h3F, 6'h01};
        lane_tbl[0] = '{3'd0, 4'b0001};
        lane_tbl[1] = '{3'd1, 4'b0010};
        lane_tbl[2] = '{3'd2, 4'b0100};
        lane_tbl[3] = '{3'd3, 4'b1000};
        lane_tbl[4] = '{3'd4, 4'b0000};
        lane_tbl[5] = '{3'd7, 4'b0000};

        rst          = 1'b1;
        bus.in_valid = '0;
        bus.wb_ready = 1'b0;
        for (int i = 0; i < N; i++) res[i] = '0;
        @(posedge clk);
        @(negedge clk);
        do_reset();
        step();
        chk("reset_wb_valid", last_wb_valid, 1'b0);
        chk("reset_retire", last_retire, 32'd0);

        // single add result
        res[0] = '{5'd3, 3'd0, 32'h3F800000};
        bus.in_valid = 6'b000001;
        bus.wb_ready = 1'b1;
        step();
        chk("t1_accept", last_ready, 6'b000001);
        bus.in_valid = '0;
        step();
        chk("t1_wb_valid", last_wb_valid, 1'b1);
        chk("t1_reg", last_reg, 5'd3);
        chk("t1_mask", last_mask, 4'b0001);
        step();
        chk("t1_done", last_done, 1'b1);
        chk("t1_retire", last_retire, 32'd1);

        // round-robin with every unit requesting
        do_reset();
        for (int i = 0; i < N; i++) res[i] = '{5'(i + 1), 3'(i % VW), $urandom};
        bus.wb_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bus.in_valid = arb_tbl[c].valid;
            step();
            chk("t2_grant", last_ready, arb_tbl[c].exp_grant);
            for (int k = 0; k < N; k++) if (m_last_acc[k]) res[k].v = $urandom;
        end
        bus.in_valid = '0;
        for (int c = 0; c < 3; c++) step();

        // lane placement including out-of-range offsets
        for (int i = 0; i < 6; i++) begin
            res[i % N] = '{5'(20 + i), lane_tbl[i].off, $urandom};
            bus.in_valid = '0;
            bus.in_valid[i % N] = 1'b1;
            step();
            bus.in_valid = '0;
            step();
            chk("lane_mask", last_mask, lane_tbl[i].exp_mask);
            chk("lane_wb_valid", last_wb_valid, 1'b1);
            step();
        end

        // backpressure fills the buffer, then drains in acceptance order
        do_reset();
        bus.wb_ready = 1'b0;
        res[0] = '{5'd10, 3'd1, 32'hAAAA0001};
        res[1] = '{5'd11, 3'd2, 32'hBBBB0002};
        res[2] = '{5'd12, 3'd3, 32'hCCCC0003};
        bus.in_valid = 6'b000011;
        step();
        bus.in_valid = bus.in_valid & ~m_last_acc;
        step();
        bus.in_valid = 6'b000100;
        step();
        chk("t3_full_count", last_count, 2'd2);
        chk("t3_blocked", last_ready, 6'b000000);
        bus.in_valid = '0;
        bus.wb_ready = 1'b1;
        step();
        chk("t3_first", last_reg, 5'd10);
        step();
        chk("t3_second", last_reg, 5'd11);
        step();

        // simultaneous enqueue and dequeue at count 1
        bus.wb_ready = 1'b1;
        res[2] = '{5'd7, 3'd2, $urandom};
        bus.in_valid = 6'b000100;
        step();
        base = int'(last_retire);
        for (int c = 0; c < 10; c++) begin
            res[2].v = $urandom;
            step();
            chk("t4_count", last_count, 2'd1);
            chk("t4_no_bubble", last_wb_valid, 1'b1);
        end
        bus.in_valid = '0;
        step();
        chk("t4_retires", last_retire - 32'(base), 32'd10);
        step();

        // reset with a full buffer
        do_reset();
        bus.wb_ready = 1'b0;
        res[3] = '{5'd13, 3'd0, 32'h11111111};
        res[4] = '{5'd14, 3'd1, 32'h22222222};
        bus.in_valid = 6'b011000;
        step();
        bus.in_valid = bus.in_valid & ~m_last_acc;
        step();
        bus.in_valid = '0;
        step();
        chk("t5_full", last_count, 2'd2);
        bus.wb_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t5_wb_valid", last_wb_valid, 1'b0);
        chk("t5_rr_ptr", last_rrptr, 3'd0);
        chk("t5_retire", last_retire, 32'd0);
        chk("t5_no_done", last_done, 1'b0);
        step();
        chk("t5_no_done_late", last_done, 1'b0);

        // retire counter wrap
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt;
        m_retire = 32'hFFFFFFFF;
        res[5] = '{5'd31, 3'd3, 32'h40490FDB};
        bus.in_valid = 6'b100000;
        step();
        bus.in_valid = '0;
        step();
        step();
        chk("t6_wrap", last_retire, 32'd0);
        chk("t6_done_reg", bus.done_reg_addr, 5'd31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
